sd_bus_byte_bridge: RTL

- Upstream feeder of the SD-card byte-window peripheral: 512-byte sector buffer at offsets 0..511, SD address bytes at 512..515, control at 516.
- Converts one 32-bit CPU load/store with byte enables into a sequence of single-byte request/data-valid transactions on the peripheral's 12-bit byte port.
- Reassembles read bytes into a little-endian word, returns a one-cycle completion pulse, and flags out-of-window or timed-out accesses.

---
 rtl/sd_bus_byte_bridge_pkg.sv | 30 +++
 rtl/sd_bus_byte_bridge_if.sv | 37 +++
 rtl/sd_bus_byte_bridge_lane_sel.sv | 23 ++
 rtl/sd_bus_byte_bridge.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sd_bus_byte_bridge_pkg.sv
// Shared types and constants for the SD byte-window bridge.
package sd_bridge_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    // Peripheral byte-window map: sector buffer, SD address bytes, control.
    localparam logic [11:0] SD_BUF_LAST = 12'd511;
    localparam logic [11:0] SD_ADDR0    = 12'd512;
    localparam logic [11:0] SD_ADDR1    = 12'd513;
    localparam logic [11:0] SD_ADDR2    = 12'd514;
    localparam logic [11:0] SD_ADDR3    = 12'd515;
    localparam logic [11:0] SD_CTRL     = 12'd516;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // CPU access captured at acceptance.
    typedef struct packed {
        logic                                we;
        logic [NUM_LANES-1:0][LANE_W-1:0]    wdata;
        logic [NUM_LANES-1:0]                be;
        logic [11:0]                         offset;
    } req_t;

endpackage

// File: rtl/sd_bus_byte_bridge_if.sv
// CPU-side and peripheral-side signals of the bridge.
interface sd_bus_byte_bridge_if;
    import sd_bridge_pkg::*;

    logic                              i_cpu_req;
    logic                              i_cpu_we;
    logic [31:0]                       i_cpu_addr;
    logic [31:0]                       i_cpu_wdata;
    logic [NUM_LANES-1:0]              i_cpu_be;
    logic [31:0]                       o_cpu_rdata;
    logic                              o_cpu_done;
    logic                              o_cpu_err;
    logic                              o_cpu_busy;
    logic [11:0]                       o_dev_address;
    logic [LANE_W-1:0]                 o_dev_data;
    logic                              o_dev_write;
    logic                              o_dev_request;
    logic [LANE_W-1:0]                 i_dev_data;
    logic                              i_dev_data_DV;

    // Environment side: CPU and peripheral.
    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_be,
        input  o_cpu_rdata, o_cpu_done, o_cpu_err, o_cpu_busy,
        input  o_dev_address, o_dev_data, o_dev_write, o_dev_request,
        output i_dev_data, i_dev_data_DV
    );

    // Bridge side.
    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_be,
        output o_cpu_rdata, o_cpu_done, o_cpu_err, o_cpu_busy,
        output o_dev_address, o_dev_data, o_dev_write, o_dev_request,
        input  i_dev_data, i_dev_data_DV
    );

endinterface

// File: rtl/sd_bus_byte_bridge_lane_sel.sv
// Finds the lowest enabled byte lane at or above a starting lane.
module sd_bridge_lane_sel
    import sd_bridge_pkg::*;
(
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [2:0]           from_i,   // 3 bits so "past lane 3" is expressible
    output logic [1:0]           lane_o,
    output logic                 none_o
);

    // Scan from the top down so the lowest qualifying lane wins.
    always_comb begin
        lane_o = '0;
        none_o = 1'b1;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (be_i[k] && (3'(k) >= from_i)) begin
                lane_o = 2'(k);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_bus_byte_bridge.sv
// Splits a 32-bit CPU access into byte transactions on the SD window port.
module sd_bus_byte_bridge
    import sd_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          WIN_BYTES = 4096,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sd_bus_byte_bridge_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]                       state_q, state_d;
    req_t                             req_q, req_d;
    logic [1:0]                       lane_q, lane_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_LANES-1:0][LANE_W-1:0] rdata_q, rdata_d;
    logic                             err_q, err_d;
    logic [11:0]                      addr_q, addr_d;
    logic [LANE_W-1:0]                data_q, data_d;

    logic [31:0]                      off_full;
    logic                             out_of_win;
    logic [NUM_LANES-1:0][LANE_W-1:0] wdata_in;

    logic [NUM_LANES-1:0]             sel_be;
    logic [2:0]                       sel_from;
    logic [1:0]                       sel_lane;
    logic                             sel_none;

    // Offset is a full 32-bit difference so addresses below BASE wrap high and fault.
    assign off_full   = (bus.i_cpu_addr - BASE_ADDR) & ~32'd3;
    assign out_of_win = off_full >= 32'(WIN_BYTES);
    assign wdata_in   = bus.i_cpu_wdata;

    // One finder serves both first-lane pick (IDLE) and advance (WAIT).
    assign sel_be   = (state_q == S_IDLE) ? bus.i_cpu_be : req_q.be;
    assign sel_from = (state_q == S_IDLE) ? 3'd0 : ({1'b0, lane_q} + 3'd1);

    sd_bridge_lane_sel u_lane_sel (
        .be_i   (sel_be),
        .from_i (sel_from),
        .lane_o (sel_lane),
        .none_o (sel_none)
    );

    // Next-state logic for the accept / issue / wait / done sequence.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_cpu_req) begin
                    req_d.we     = bus.i_cpu_we;
                    req_d.wdata  = wdata_in;
                    req_d.be     = bus.i_cpu_be;
                    req_d.offset = off_full[11:0];
                    rdata_d      = '0;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    if (out_of_win) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.i_cpu_be == '0) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d  = sel_lane;
                        addr_d  = off_full[11:0] + {10'd0, sel_lane};
                        data_d  = wdata_in[sel_lane];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_dev_data_DV) begin
                    if (!req_q.we) rdata_d[lane_q] = bus.i_dev_data;
                    if (sel_none) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d  = sel_lane;
                        addr_d  = req_q.offset + {10'd0, sel_lane};
                        data_d  = req_q.wdata[sel_lane];
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon remaining lanes; already captured bytes stay.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight without a done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_dev_request = (state_q == S_ISSUE);
    assign bus.o_dev_write   = req_q.we && ((state_q == S_ISSUE) || (state_q == S_WAIT));
    assign bus.o_dev_address = addr_q;
    assign bus.o_dev_data    = data_q;
    assign bus.o_cpu_done    = (state_q == S_DONE);
    assign bus.o_cpu_err     = (state_q == S_DONE) && err_q;
    assign bus.o_cpu_busy    = (state_q != S_IDLE);
    assign bus.o_cpu_rdata   = rdata_q;

endmodule
